// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the MIPS single-cycle core.
// Owns the PC, selects the next PC, stalls on instruction-memory readiness,
// and injects interrupt / illegal-opcode traps with a return address for $26.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic [1:0]  PCSrc,
    input  logic        branch_taken,
    input  logic [31:0] ConBA,
    input  logic [25:0] JT,
    input  logic [31:0] jr_addr,
    input  logic        illop,
    input  logic        irq,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic        commit,
    output logic        trap_we,
    output logic [31:0] trap_epc,
    output logic        kernel
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_trap_epc;
    logic [31:0] w_epc_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        r_irq_pend;
    logic        w_irq_pend_nxt;
    logic        r_trap_we;
    logic        w_trap_we_nxt;
    logic        w_commit;
    logic        w_take_irq;

    // Sequential increment; bit 31 (kernel bit) is never carried into.
    always_comb begin
        w_pc_plus4 = {r_pc[31], r_pc[30:0] + 31'd4};
    end

    // Next-PC selection for a committing instruction; JR may drop but never gain the kernel bit.
    always_comb begin
        w_target = w_pc_plus4;
        case (PCSrc)
            2'd0:    w_target = w_pc_plus4;
            2'd1:    w_target = branch_taken ? ConBA : w_pc_plus4;
            2'd2:    w_target = {w_pc_plus4[31:28], JT, 2'b00};
            2'd3:    w_target = {r_pc[31] & jr_addr[31], jr_addr[30:0]};
            default: w_target = w_pc_plus4;
        endcase
    end

    // Next-state, trap entry and commit decision; illop outranks a pending interrupt.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_epc_nxt     = r_trap_epc;
        w_trap_we_nxt = 1'b0;
        w_commit      = 1'b0;
        w_take_irq    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    if (illop) begin
                        w_pc_nxt      = EXC_VEC;
                        w_epc_nxt     = w_pc_plus4;
                        w_trap_we_nxt = 1'b1;
                        w_state_nxt   = ST_TRAP;
                    end else if (r_irq_pend && !r_pc[31]) begin
                        // Interrupted instruction has not retired, so it re-executes on return.
                        w_pc_nxt      = IRQ_VEC;
                        w_epc_nxt     = r_pc;
                        w_trap_we_nxt = 1'b1;
                        w_take_irq    = 1'b1;
                        w_state_nxt   = ST_TRAP;
                    end else begin
                        w_commit = 1'b1;
                        w_pc_nxt = w_target;
                    end
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_TRAP: begin
                w_state_nxt = ST_FETCH;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
        // A new request in the same cycle as the take keeps the flag set.
        w_irq_pend_nxt = irq | (r_irq_pend & ~w_take_irq);
    end

    // Architectural state register with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VEC;
            r_irq_pend <= 1'b0;
            r_trap_we  <= 1'b0;
            r_trap_epc <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_irq_pend <= w_irq_pend_nxt;
            r_trap_we  <= w_trap_we_nxt;
            r_trap_epc <= w_epc_nxt;
        end
    end

    assign PC       = r_pc;
    assign PCplus4  = w_pc_plus4;
    assign commit   = w_commit & ~reset;
    assign trap_we  = r_trap_we;
    assign trap_epc = r_trap_epc;
    assign kernel   = r_pc[31];

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the MIPS single-cycle core. Owns the PC register and selects the next PC from PC+4, the branch target (ConBA from the immediate-extension block), the jump target and the JR register value. Stalls on instruction-memory readiness and injects interrupt and illegal-opcode traps. Issues a one-cycle commit strobe that gates all architectural writes, plus a trap-write strobe that saves the return address to $26.

Parameters:
RESET_VEC, 32'h8000_0000, PC loaded on reset (kernel space)
IRQ_VEC, 32'h8000_0004, interrupt entry address
EXC_VEC, 32'h8000_0008, illegal-opcode entry address

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
imem_ready  in  1  instruction word valid this cycle
PCSrc  in  2  0=PC+4, 1=branch, 2=jump, 3=JR
branch_taken  in  1  branch condition true (used only when PCSrc=1)
ConBA  in  32  branch target from the extension block
JT  in  26  jump-target field of the instruction
jr_addr  in  32  rs value for JR/JALR
illop  in  1  decoder flags the current instruction as illegal
irq  in  1  external interrupt request, level
PC  out  32  current PC
PCplus4  out  32  {PC[31], PC[30:0]+4}
commit  out  1  current instruction retires; enables RF/DM writes
trap_we  out  1  write trap_epc into $26
trap_epc  out  32  return address for the trap
kernel  out  1  equals PC[31]

Behaviour:
- Reset, sampled on the clock edge: PC=RESET_VEC, state=BOOT, irq_pend=0, commit=0, trap_we=0, trap_epc=0. Reset overrides every other event, including a trap in progress.
- States: BOOT, FETCH, TRAP.
- BOOT: lasts one cycle, then goes to FETCH. PC holds and commit=0.
- FETCH, imem_ready=0: PC holds, commit=0, no state change (stall of any length).
- FETCH, imem_ready=1, priority order:
  1. illop=1: commit=0 (instruction squashed). PC<=EXC_VEC, trap_epc<=PCplus4, state<=TRAP.
  2. Otherwise irq_pend=1 and kernel=0: commit=0. PC<=IRQ_VEC, trap_epc<=PC (the instruction re-executes after return), irq_pend<=0, state<=TRAP.
  3. Otherwise: commit=1 combinationally in this cycle, and PC<=next.
- Next-PC selection:
  - PCSrc=0: PCplus4.
  - PCSrc=1: ConBA if branch_taken, else PCplus4.
  - PCSrc=2: {PCplus4[31:28], JT, 2'b00}.
  - PCSrc=3: {PC[31] & jr_addr[31], jr_addr[30:0]}. User code cannot enter kernel space through JR; kernel code may leave it.
- PC+4 wraps within bits [30:0] and never alters bit 31. 32'h7FFF_FFFC+4 = 32'h0000_0000.
- TRAP: lasts one cycle. trap_we=1, commit=0, PC holds, then state<=FETCH. trap_epc is registered and stable while trap_we=1.
- Interrupt pending flag:
  - irq_pend<=1 on any cycle with irq=1.
  - Cleared only when the interrupt is taken, or by reset.
  - irq is ignored for entry while kernel=1; the flag stays pending until PC[31]=0.
- Simultaneous events:
  - illop together with a pending irq: illop wins and irq_pend is retained.
  - irq asserting in the same cycle as a commit is taken at the next imem_ready.
- commit and trap_we are never both 1 in the same cycle.
- PC changes only on a commit, on trap entry or on reset.
- All outputs are registered except commit and PCplus4, which are combinational from the state, the inputs and PC.

Test Plan:
1. Reset, then imem_ready=1 with PCSrc=0 for 3 cycles -> PC=8000_0000 (BOOT), then 8000_0000, 8000_0004, 8000_0008; commit=0 in BOOT and 1 thereafter.
2. PC=0000_0100, PCSrc=1, ConBA=0000_0040: branch_taken=1 gives PC=0000_0040; branch_taken=0 gives 0000_0104. With imem_ready=0 for 4 cycles, PC holds and commit=0.
3. PC=0040_0000, PCSrc=3, jr_addr=8000_1000 -> PC=0000_1000 (kernel bit blocked). From PC=8000_0010 the same jr_addr gives 8000_1000.
4. PC=0000_2000, irq pulse for 1 cycle, then imem_ready -> commit=0, next PC=8000_0004, following cycle trap_we=1 with trap_epc=0000_2000, then FETCH; irq_pend cleared.
5. PC=8000_0050 (kernel), irq held -> no trap. JR to 0000_3000 commits, then the next fetch traps with trap_epc=0000_3000.
6. illop=1 and irq_pend=1 at PC=0000_0200 -> PC=8000_0008, trap_epc=0000_0204; after returning to user code the interrupt is taken. Reset asserted during TRAP -> PC=8000_0000, trap_we=0, irq_pend=0.
